// File: rtl/reg_file_pkg.sv
// Shared types and default parameters for the context-switching register file.
package reg_file_pkg;
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} ctx_state_t;

  localparam int W_DEF       = 8;
  localparam int D_DEF       = 3;
  localparam int R_DEF       = 2;
  localparam int ZERO_R0_DEF = 0;
endpackage

// File: rtl/reg_file_ctx_fsm.sv
// Save/restore sequencer: walks idx over every register and flags the copy direction.
module reg_file_ctx_fsm
  import reg_file_pkg::*;
#(
  parameter int D = D_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_save_req,
  input  logic         i_restore_req,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_copy_en,
  output logic         o_copy_dir,
  output logic [D-1:0] o_idx
);
  localparam logic [D-1:0] IDX_LAST = '1;

  ctx_state_t   r_state;
  logic [D-1:0] r_idx;
  logic         r_busy;
  logic         r_done;
  logic         r_copy_dir;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_copy_dir <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_idx <= '0;
          if (i_save_req) begin
            r_state    <= SAVE;
            r_busy     <= 1'b1;
            r_copy_dir <= 1'b0;
          end else if (i_restore_req) begin
            r_state    <= RESTORE;
            r_busy     <= 1'b1;
            r_copy_dir <= 1'b1;
          end
        end
        SAVE, RESTORE: begin
          // Terminal count compared explicitly; idx also returns to 0 for the next run.
          if (r_idx == IDX_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_copy_en  = r_busy;
  assign o_copy_dir = r_copy_dir;
  assign o_idx      = r_idx;
endmodule

// File: rtl/reg_file_ctx.sv
// Multi-read-port register file with write bypass, optional zero r0 and a shadow bank
// for whole-context save/restore.
module reg_file_ctx
  import reg_file_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int D       = D_DEF,
  parameter int R       = R_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_reg_write_en,
  input  logic [D-1:0]   i_reg_write_address,
  input  logic [W-1:0]   i_reg_write_data,
  input  logic [R*D-1:0] i_reg_read_address,
  output logic [R*W-1:0] o_source_data,
  input  logic           i_save_req,
  input  logic           i_restore_req,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_write_blocked
);
  localparam int   DEPTH = 1 << D;
  localparam logic W_ZR0 = (ZERO_R0 != 0);

  logic [W-1:0] r_regs   [DEPTH];
  logic [W-1:0] r_shadow [DEPTH];

  logic         w_busy;
  logic         w_copy_en;
  logic         w_copy_dir;
  logic [D-1:0] w_idx;
  logic         w_wr_accept;

  reg_file_ctx_fsm #(.D(D)) u_fsm (
    .i_clk         (i_clk),
    .i_rst         (i_reset),
    .i_save_req    (i_save_req),
    .i_restore_req (i_restore_req),
    .o_busy        (w_busy),
    .o_done        (o_done),
    .o_copy_en     (w_copy_en),
    .o_copy_dir    (w_copy_dir),
    .o_idx         (w_idx)
  );

  // Reset gating keeps bypassed data off the read ports while the bank is being cleared.
  assign w_wr_accept = i_reg_write_en && !w_busy && !i_reset &&
                       !(W_ZR0 && (i_reg_write_address == '0));
  assign o_busy          = w_busy;
  assign o_write_blocked = i_reg_write_en && w_busy;

  for (genvar k = 0; k < R; k++) begin : g_rd
    logic [D-1:0] w_addr;
    assign w_addr = i_reg_read_address[k*D +: D];
    assign o_source_data[k*W +: W] =
      (W_ZR0 && (w_addr == '0))                          ? '0 :
      (w_wr_accept && (w_addr == i_reg_write_address))   ? i_reg_write_data :
                                                           r_regs[w_addr];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      if (w_wr_accept)
        r_regs[i_reg_write_address] <= i_reg_write_data;
      if (w_copy_en && !w_copy_dir)
        r_shadow[w_idx] <= r_regs[w_idx];
      if (w_copy_en && w_copy_dir)
        r_regs[w_idx] <= (W_ZR0 && (w_idx == '0)) ? '0 : r_shadow[w_idx];
    end
  end
endmodule

// File: tb/tb_reg_file_ctx.sv
// Directed bench for reg_file_ctx: bypass, zero r0, save/restore timing and reset abort.
module tb_reg_file_ctx;
  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  wa;
  logic [7:0]  wd;
  logic [5:0]  ra;
  logic        save_req;
  logic        restore_req;
  logic [15:0] src;
  logic        busy;
  logic        done;
  logic        wblk;
  logic [15:0] src_z;
  logic        busy_z;
  logic        done_z;
  logic        wblk_z;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_ctx #(.W(8), .D(3), .R(2), .ZERO_R0(0)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_reg_write_en(we), .i_reg_write_address(wa),
    .i_reg_write_data(wd), .i_reg_read_address(ra), .o_source_data(src),
    .i_save_req(save_req), .i_restore_req(restore_req), .o_busy(busy),
    .o_done(done), .o_write_blocked(wblk)
  );

  reg_file_ctx #(.W(8), .D(3), .R(2), .ZERO_R0(1)) u_dut_z (
    .i_clk(clk), .i_reset(rst), .i_reg_write_en(we), .i_reg_write_address(wa),
    .i_reg_write_data(wd), .i_reg_read_address(ra), .o_source_data(src_z),
    .i_save_req(save_req), .i_restore_req(restore_req), .o_busy(busy_z),
    .o_done(done_z), .o_write_blocked(wblk_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; wa = a; wd = d;
    step();
    we = 1'b0;
  endtask

  // Counts busy cycles and done pulses over a bounded window starting after the request edge.
  task automatic watch(input int cycles, output int bcnt, output int dcnt);
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      bcnt += int'(busy);
      dcnt += int'(done);
      step();
    end
  endtask

  task automatic read_all(input string tag, input logic [7:0] base, input logic [7:0] stride);
    for (int i = 0; i < 8; i++) begin
      ra[2:0] = 3'(i);
      #1;
      check_val($sformatf("%s_r%0d", tag, i), {24'd0, src[7:0]}, {24'd0, base + 8'(i) * stride});
      step();
    end
  endtask

  int bc, dc;

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
    save_req = 1'b0; restore_req = 1'b0;

    // Reset: outputs idle and bypass suppressed even with a matching write presented.
    #12;
    we = 1'b1; wa = 3'd3; wd = 8'h5A; ra = {3'd3, 3'd3};
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_wblk", {31'd0, wblk}, 32'd0);
    check_val("rst_src",  {16'd0, src},  32'd0);
    we = 1'b0;
    rst = 1'b0;
    step();

    // Write reg3, same-cycle bypass then array read.
    we = 1'b1; wa = 3'd3; wd = 8'h5A; ra = {3'd0, 3'd3};
    #1;
    check_val("byp_r3", {24'd0, src[7:0]}, 32'h5A);
    step();
    we = 1'b0;
    #1;
    check_val("arr_r3", {24'd0, src[7:0]}, 32'h5A);

    // Zero r0: hardwired instance reads 0, plain instance sees the write.
    step();
    we = 1'b1; wa = 3'd0; wd = 8'hFF; ra = {3'd0, 3'd3};
    #1;
    check_val("z_byp_r0",  {24'd0, src_z[15:8]}, 32'h00);
    check_val("nz_byp_r0", {24'd0, src[15:8]},   32'hFF);
    step();
    we = 1'b0;
    #1;
    check_val("z_arr_r0",  {24'd0, src_z[15:8]}, 32'h00);
    check_val("nz_arr_r0", {24'd0, src[15:8]},   32'hFF);
    step();

    // Load 0x10..0x17 and save; a write at busy cycle 2 targets reg2 and must be dropped.
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin
        we = 1'b1; wa = 3'd2; wd = 8'hEE; ra[2:0] = 3'd2;
        #1;
        check_val("save_wblk", {31'd0, wblk}, 32'd1);
        check_val("save_nobyp", {24'd0, src[7:0]}, 32'h12);
      end else begin
        #1;
      end
      bc += int'(busy);
      dc += int'(done);
      step();
      we = 1'b0;
    end
    check_val("save_busy_cycles", bc, 32'd8);
    check_val("save_done_pulses", dc, 32'd1);
    ra[2:0] = 3'd2;
    #1;
    check_val("save_r2_kept", {24'd0, src[7:0]}, 32'h12);
    step();

    // Clobber everything, restore, and expect the saved image back.
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h00);
    ra[2:0] = 3'd5;
    #1;
    check_val("clobber_r5", {24'd0, src[7:0]}, 32'h00);
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    watch(12, bc, dc);
    check_val("rest_busy_cycles", bc, 32'd8);
    check_val("rest_done_pulses", dc, 32'd1);
    read_all("rest", 8'h10, 8'h01);

    // Simultaneous requests take SAVE; a restore during busy is ignored.
    wr(3'd0, 8'hAA);
    save_req = 1'b1; restore_req = 1'b1;
    step();
    save_req = 1'b0; restore_req = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 25; i++) begin
      restore_req = (i == 3);
      #1;
      bc += int'(busy);
      dc += int'(done);
      step();
    end
    restore_req = 1'b0;
    check_val("both_busy_cycles", bc, 32'd8);
    check_val("both_done_pulses", dc, 32'd1);
    ra[2:0] = 3'd0;
    #1;
    check_val("both_r0_saved", {24'd0, src[7:0]}, 32'hAA);
    step();

    // Reset in the 4th cycle of a restore aborts it and clears both banks.
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    step(); step(); step();
    #1;
    check_val("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    #1;
    rst = 1'b0;
    step();
    watch(12, bc, dc);
    check_val("abort_no_done", dc, 32'd0);
    read_all("abort_main", 8'h00, 8'h00);
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    watch(12, bc, dc);
    check_val("abort_rest_done", dc, 32'd1);
    read_all("abort_shadow", 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
